// File: rtl/fault_pkg.sv
// Shared types and helpers for the fault window sequencer: FSM states,
// sample width, the NORMAL fault code and a saturating absolute value.
package fault_pkg;

  localparam int SMP_W = 16;
  localparam logic [2:0] FT_NORMAL = 3'd0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACQ     = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_EVAL    = 3'd3,
    ST_TRIPPED = 3'd4
  } state_t;

  // Most-negative input maps to the most-positive value, so results never wrap negative.
  function automatic logic [SMP_W-1:0] sat_abs(input logic signed [SMP_W-1:0] x);
    if (x == {1'b1, {(SMP_W-1){1'b0}}})
      return {1'b0, {(SMP_W-1){1'b1}}};
    else if (x[SMP_W-1])
      return -x;
    else
      return x;
  endfunction

endpackage

// File: rtl/abs_peak_tracker.sv
// Running |peak| of a signed sample stream. o_peak_next already includes the
// current sample so the owner can capture a window result and clear in one cycle.
module abs_peak_tracker
  import fault_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SMP_W-1:0] i_sample,
  input  logic             i_valid,
  input  logic             i_clear,
  output logic [SMP_W-1:0] o_peak,
  output logic [SMP_W-1:0] o_peak_next
);

  logic [SMP_W-1:0] r_peak;
  logic [SMP_W-1:0] w_abs;

  assign w_abs       = sat_abs($signed(i_sample));
  assign o_peak_next = (i_valid && (w_abs > r_peak)) ? w_abs : r_peak;
  assign o_peak      = r_peak;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_peak <= '0;
    else if (i_clear)
      r_peak <= '0;
    else
      r_peak <= o_peak_next;
  end

endmodule

// File: rtl/fault_window_sequencer.sv
// Collects per-window |V|/|I| peaks, hands them to the fault classifier,
// debounces its verdict across windows and latches a trip.
module fault_window_sequencer
  import fault_pkg::*;
#(
  parameter int WIN_LEN = 64,
  parameter int CONFIRM = 3,
  parameter int CLS_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic [SMP_W-1:0] vc_sample,
  input  logic [SMP_W-1:0] ic_sample,
  output logic [SMP_W-1:0] Vc_peak,
  output logic [SMP_W-1:0] Ic_peak,
  input  logic [2:0]       fault_type,
  output logic             win_done,
  output logic [2:0]       last_type,
  output logic             trip,
  output logic [2:0]       trip_type,
  input  logic             trip_clear,
  output logic [2:0]       dbg_state
);

  // Handshake: a sample transfers on a rising clk edge where sample_valid && sample_ready;
  // sample_ready is registered and high only in ACQ, and a non-accepted sample is ignored.

  localparam logic [15:0] CNT_LAST    = 16'(WIN_LEN - 1);
  localparam logic [2:0]  SETTLE_LAST = 3'(CLS_LAT - 1);
  localparam logic [3:0]  CONF_MAX    = 4'(CONFIRM);

  state_t           r_state;
  logic [15:0]      r_cnt;
  logic [2:0]       r_settle;
  logic [2:0]       r_pend;
  logic [3:0]       r_conf;
  logic             r_ready;
  logic [SMP_W-1:0] r_vc_peak;
  logic [SMP_W-1:0] r_ic_peak;
  logic             r_win_done;
  logic [2:0]       r_last_type;
  logic             r_trip;
  logic [2:0]       r_trip_type;

  logic             w_xfer;
  logic             w_last;
  logic             w_clear;
  logic             w_abort;
  logic [SMP_W-1:0] w_v_peak;
  logic [SMP_W-1:0] w_i_peak;
  logic [SMP_W-1:0] w_v_next;
  logic [SMP_W-1:0] w_i_next;
  logic [2:0]       w_pend_next;
  logic [3:0]       w_conf_next;

  assign w_xfer  = sample_valid && r_ready;
  assign w_last  = w_xfer && (r_cnt == CNT_LAST);
  assign w_clear = (r_state != ST_ACQ) || w_last;
  assign w_abort = !enable &&
                   ((r_state == ST_ACQ) || (r_state == ST_SETTLE) || (r_state == ST_EVAL));

  abs_peak_tracker u_v_peak (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_sample    (vc_sample),
    .i_valid     (w_xfer),
    .i_clear     (w_clear),
    .o_peak      (w_v_peak),
    .o_peak_next (w_v_next)
  );

  abs_peak_tracker u_i_peak (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_sample    (ic_sample),
    .i_valid     (w_xfer),
    .i_clear     (w_clear),
    .o_peak      (w_i_peak),
    .o_peak_next (w_i_next)
  );

  // A NORMAL verdict resets the streak but keeps the pending code.
  always_comb begin
    w_pend_next = r_pend;
    w_conf_next = r_conf;
    if (fault_type == FT_NORMAL) begin
      w_conf_next = 4'd0;
    end else if (fault_type == r_pend) begin
      if (r_conf < CONF_MAX)
        w_conf_next = r_conf + 4'd1;
    end else begin
      w_pend_next = fault_type;
      w_conf_next = 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_settle    <= '0;
      r_pend      <= '0;
      r_conf      <= '0;
      r_ready     <= 1'b0;
      r_vc_peak   <= '0;
      r_ic_peak   <= '0;
      r_win_done  <= 1'b0;
      r_last_type <= '0;
      r_trip      <= 1'b0;
      r_trip_type <= '0;
    end else begin
      r_win_done <= 1'b0;
      if (w_abort) begin
        r_state <= ST_IDLE;
        r_ready <= 1'b0;
        r_cnt   <= '0;
        r_pend  <= '0;
        r_conf  <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (enable) begin
              r_state <= ST_ACQ;
              r_ready <= 1'b1;
              r_cnt   <= '0;
            end
          end
          ST_ACQ: begin
            if (w_last) begin
              r_vc_peak <= w_v_next;
              r_ic_peak <= w_i_next;
              r_cnt     <= '0;
              r_ready   <= 1'b0;
              r_settle  <= '0;
              r_state   <= ST_SETTLE;
            end else if (w_xfer) begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
          ST_SETTLE: begin
            if (r_settle == SETTLE_LAST)
              r_state <= ST_EVAL;
            else
              r_settle <= r_settle + 3'd1;
          end
          ST_EVAL: begin
            r_win_done  <= 1'b1;
            r_last_type <= fault_type;
            r_pend      <= w_pend_next;
            r_conf      <= w_conf_next;
            if (w_conf_next == CONF_MAX) begin
              r_trip      <= 1'b1;
              r_trip_type <= fault_type;
              r_state     <= ST_TRIPPED;
            end else begin
              r_state <= ST_ACQ;
              r_ready <= 1'b1;
            end
          end
          ST_TRIPPED: begin
            if (trip_clear) begin
              r_trip      <= 1'b0;
              r_trip_type <= '0;
              r_pend      <= '0;
              r_conf      <= '0;
              r_cnt       <= '0;
              r_state     <= enable ? ST_ACQ : ST_IDLE;
              r_ready     <= enable;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sample_ready = r_ready;
  assign Vc_peak      = r_vc_peak;
  assign Ic_peak      = r_ic_peak;
  assign win_done     = r_win_done;
  assign last_type    = r_last_type;
  assign trip         = r_trip;
  assign trip_type    = r_trip_type;
  assign dbg_state    = r_state;

endmodule
